// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and WB operand snooping
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int CTRL_W     = 12,
    parameter int PERF_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [4:0]            id_rs1_addr,
    input  logic [4:0]            id_rs2_addr,
    input  logic [4:0]            id_rd_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic                  flush,
    input  logic                  ex_stall,
    input  logic                  wb_reg_write,
    input  logic [4:0]            wb_rd_addr,
    input  logic [XLEN-1:0]       wb_rd_data,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [4:0]            ex_rs1_addr,
    output logic [4:0]            ex_rs2_addr,
    output logic [4:0]            ex_rd_addr,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic                  load_use_stall,
    output logic [PERF_CNT_W-1:0] bubble_count
);
    logic                  valid_q, valid_d;
    logic [XLEN-1:0]       pc_q, pc_d, imm_q, imm_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [4:0]            rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [PERF_CNT_W-1:0] cnt_q, cnt_d;
    logic                  hazard;

    function automatic logic wbhit(input logic [4:0] a);
        return wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == a;
    endfunction

    assign hazard = valid_q && ctrl_q[10] && rd_addr_q != 5'd0 &&
                    ((id_uses_rs1 && id_rs1_addr == rd_addr_q) || (id_uses_rs2 && id_rs2_addr == rd_addr_q));
    assign load_use_stall = hazard && !flush && !ex_stall;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;
        if (flush || (!ex_stall && (hazard || !id_valid))) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_addr_d  = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            ctrl_d     = '0;
        end else if (ex_stall) begin
            rs1_data_d = (valid_q && wbhit(rs1_addr_q)) ? wb_rd_data : rs1_data_q;
            rs2_data_d = (valid_q && wbhit(rs2_addr_q)) ? wb_rd_data : rs2_data_q;
        end else begin
            valid_d    = 1'b1;
            pc_d       = id_pc;
            rs1_addr_d = id_rs1_addr;
            rs2_addr_d = id_rs2_addr;
            rd_addr_d  = id_rd_addr;
            rs1_data_d = wbhit(id_rs1_addr) ? wb_rd_data : id_rs1_data;
            rs2_data_d = wbhit(id_rs2_addr) ? wb_rd_data : id_rs2_data;
            imm_d      = id_imm;
            ctrl_d     = id_ctrl;
        end
        if (load_use_stall && !(&cnt_q))
            cnt_d = cnt_q + PERF_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            ctrl_q     <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs1_addr  = rs1_addr_q;
    assign ex_rs2_addr  = rs2_addr_q;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_rs1_data  = rs1_data_q;
    assign ex_rs2_data  = rs2_data_q;
    assign ex_imm       = imm_q;
    assign ex_ctrl      = ctrl_q;
    assign bubble_count = cnt_q;

    a_bubble_ctrl: assert property (@(posedge clk) disable iff (rst) valid_q || ctrl_q == '0);
    a_stall_flush: assert property (@(posedge clk) disable iff (rst) !(load_use_stall && flush));
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of the ID/EX register, with a 2-bit bubble counter to reach saturation
module tb_id_ex_stage;
    logic        clk = 0, rst = 1;
    logic        id_valid, id_uses_rs1, id_uses_rs2, flush, ex_stall, wb_reg_write;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_rd_data;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
    logic [11:0] id_ctrl;
    logic        ex_valid, load_use_stall;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [11:0] ex_ctrl;
    logic [1:0]  bubble_count;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CTRL_W(12), .PERF_CNT_W(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .flush(flush), .ex_stall(ex_stall), .wb_reg_write(wb_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_rd_addr(ex_rd_addr), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic u1, input logic u2, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic [11:0] ctrl);
        id_valid = v; id_pc = pc; id_rs1_addr = r1; id_rs2_addr = r2; id_rd_addr = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = ctrl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        flush = 0; ex_stall = 0; wb_reg_write = 0; wb_rd_addr = 0; wb_rd_data = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000);
        step(); step();
        chk("rst_valid", ex_valid, 0);
        chk("rst_ctrl", ex_ctrl, 0);
        chk("rst_cnt", bubble_count, 0);
        chk("rst_pc", ex_pc, 0);
        rst = 0;
        // lw x5 enters EX
        set_id(1, 32'h100, 2, 0, 5, 1, 0, 32'h1000, 0, 4, 12'hC00);
        step();
        chk("lw_valid", ex_valid, 1);
        chk("lw_rd", ex_rd_addr, 5);
        chk("lw_ctrl", ex_ctrl, 12'hC00);
        chk("lw_pc", ex_pc, 32'h100);
        set_id(1, 32'h104, 5, 1, 6, 1, 1, 32'h0, 32'h3, 0, 12'h800);
        chk("hz_stall", load_use_stall, 1);
        step();
        chk("hz_bub_valid", ex_valid, 0);
        chk("hz_bub_ctrl", ex_ctrl, 0);
        chk("hz_bub_rs1", ex_rs1_addr, 0);
        chk("hz_cnt1", bubble_count, 1);
        chk("hz_stall_gone", load_use_stall, 0);
        step();
        chk("hz_load_rs1", ex_rs1_addr, 5);
        chk("hz_load_rd", ex_rd_addr, 6);
        chk("hz_load_valid", ex_valid, 1);
        // hazard masked by flush
        set_id(1, 32'h108, 2, 0, 5, 1, 0, 0, 0, 4, 12'hC00);
        step();
        set_id(1, 32'h10C, 5, 1, 6, 1, 1, 0, 0, 0, 12'h800);
        flush = 1; #1;
        chk("fl_stall", load_use_stall, 0);
        step();
        flush = 0;
        chk("fl_valid", ex_valid, 0);
        chk("fl_pc", ex_pc, 0);
        chk("fl_cnt", bubble_count, 1);
        // snoop on load
        wb_reg_write = 1; wb_rd_addr = 7; wb_rd_data = 32'hDEAD;
        set_id(1, 32'h110, 3, 7, 8, 1, 1, 32'h22, 32'h11, 0, 12'h800);
        step();
        chk("snp_rs2", ex_rs2_data, 32'hDEAD);
        chk("snp_rs1", ex_rs1_data, 32'h22);
        wb_rd_addr = 0;
        step();
        chk("snp_x0", ex_rs2_data, 32'h11);
        wb_reg_write = 0;
        // snoop on hold
        set_id(1, 32'h200, 9, 4, 10, 1, 1, 32'hAAAA, 32'h4, 32'h55, 12'h840);
        step();
        chk("hold_pre", ex_rs1_data, 32'hAAAA);
        ex_stall = 1;
        set_id(1, 32'h204, 1, 2, 11, 1, 1, 32'h77, 32'h88, 32'h66, 12'h800);
        step();
        chk("hold_pc1", ex_pc, 32'h200);
        wb_reg_write = 1; wb_rd_addr = 9; wb_rd_data = 32'h1234;
        step();
        wb_reg_write = 0;
        chk("hold_snp", ex_rs1_data, 32'h1234);
        step();
        chk("hold_rs1", ex_rs1_data, 32'h1234);
        chk("hold_rs2", ex_rs2_data, 32'h4);
        chk("hold_pc", ex_pc, 32'h200);
        chk("hold_rd", ex_rd_addr, 10);
        chk("hold_imm", ex_imm, 32'h55);
        chk("hold_ctrl", ex_ctrl, 12'h840);
        ex_stall = 0;
        step();
        chk("rel_pc", ex_pc, 32'h204);
        chk("rel_rd", ex_rd_addr, 11);
        chk("rel_rs1", ex_rs1_data, 32'h77);
        // lw x0 never stalls
        set_id(1, 32'h300, 2, 0, 0, 1, 0, 0, 0, 0, 12'hC00);
        step();
        set_id(1, 32'h304, 0, 0, 6, 1, 1, 0, 0, 0, 12'h800);
        chk("x0_stall", load_use_stall, 0);
        step();
        chk("x0_valid", ex_valid, 1);
        chk("x0_pc", ex_pc, 32'h304);
        // hazard held under ex_stall: no bubble, no count
        set_id(1, 32'h400, 2, 0, 5, 1, 0, 0, 0, 0, 12'hC00);
        step();
        set_id(1, 32'h404, 1, 5, 6, 0, 1, 0, 0, 0, 12'h800);
        ex_stall = 1; #1;
        chk("st_hz_stall", load_use_stall, 0);
        step(); step();
        chk("st_hz_valid", ex_valid, 1);
        chk("st_hz_cnt", bubble_count, 1);
        ex_stall = 0; #1;
        chk("st_hz_rel", load_use_stall, 1);
        step();
        chk("st_hz_cnt2", bubble_count, 2);
        chk("st_hz_bub", ex_valid, 0);
        // saturation of 2-bit counter
        for (int i = 0; i < 2; i++) begin
            set_id(1, 32'h500, 2, 0, 5, 1, 0, 0, 0, 0, 12'hC00);
            step();
            set_id(1, 32'h504, 5, 0, 6, 1, 0, 0, 0, 0, 12'h800);
            step();
            chk("sat_cnt", bubble_count, 3);
        end
        // async reset mid-stream
        step();
        chk("pre_rst_valid", ex_valid, 1);
        #2 rst = 1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_pc", ex_pc, 0);
        chk("arst_rs1", ex_rs1_addr, 0);
        chk("arst_ctrl", ex_ctrl, 0);
        chk("arst_cnt", bubble_count, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
